// File: rtl/ascon_pack.sv
// ---------------------------------------------------------------------------
// ascon_pack
// Shared definitions for the ASCON-128 control FSM:
//   state_t        - the nine controller states
//   ROUND_A_START  - value the round counter loads on init_a (p^a, 12 rounds)
//   ROUND_B_START  - value the round counter loads on init_b (p^b, 6 rounds)
//   LAST_ROUND     - index of the final round of either permutation
//   counter_next   - next value of the sibling round counter for a given
//                    en/init_a/init_b; init_a wins over init_b
// ---------------------------------------------------------------------------
package ascon_pack;

   typedef enum logic [3:0] {
      S_IDLE       = 4'd0,
      S_INIT       = 4'd1,
      S_AD_WAIT    = 4'd2,
      S_AD_ROUNDS  = 4'd3,
      S_PT_WAIT    = 4'd4,
      S_PT_ROUNDS  = 4'd5,
      S_FINAL_WAIT = 4'd6,
      S_FINAL      = 4'd7,
      S_DONE       = 4'd8
   } state_t;

   localparam logic [3:0] ROUND_A_START = 4'd0;
   localparam logic [3:0] ROUND_B_START = 4'd6;
   localparam logic [3:0] LAST_ROUND    = 4'd11;

   function automatic logic [3:0] counter_next(input logic [3:0] round,
                                               input logic       en,
                                               input logic       init_a,
                                               input logic       init_b);
      logic [3:0] nxt;
      nxt = round;
      if (en) begin
         if (init_a)      nxt = ROUND_A_START;
         else if (init_b) nxt = ROUND_B_START;
         else             nxt = round + 4'd1;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/ascon_ctrl_fsm_if.sv
// ---------------------------------------------------------------------------
// ascon_ctrl_fsm_if
// Bundles the controller's handshake, round-counter and datapath-strobe
// signals.
//   slave  : the controller side (consumes start/data_valid/round,
//            drives everything else)
//   master : the environment side (upstream data source, round counter,
//            permutation datapath)
//
// Data handshake: a block is transferred in exactly the cycle where
// data_valid_i && data_ready_o are both high. data_ready_o does not depend
// on data_valid_i, data_valid_i may be raised or dropped at any time, and
// data_valid_i is ignored whenever data_ready_o is low.
// ---------------------------------------------------------------------------
interface ascon_ctrl_fsm_if;
   logic       start_i;
   logic       data_valid_i;
   logic [3:0] round_i;
   logic       data_ready_o;
   logic       en_cpt_o;
   logic       init_a_o;
   logic       init_b_o;
   logic       perm_en_o;
   logic       load_init_o;
   logic       xor_data_o;
   logic       xor_key_begin_o;
   logic       xor_key_end_o;
   logic       xor_domain_o;
   logic       cipher_valid_o;
   logic       tag_valid_o;
   logic       done_o;

   modport slave (
      input  start_i, data_valid_i, round_i,
      output data_ready_o, en_cpt_o, init_a_o, init_b_o, perm_en_o,
             load_init_o, xor_data_o, xor_key_begin_o, xor_key_end_o,
             xor_domain_o, cipher_valid_o, tag_valid_o, done_o
   );

   modport master (
      output start_i, data_valid_i, round_i,
      input  data_ready_o, en_cpt_o, init_a_o, init_b_o, perm_en_o,
             load_init_o, xor_data_o, xor_key_begin_o, xor_key_end_o,
             xor_domain_o, cipher_valid_o, tag_valid_o, done_o
   );
endinterface

// File: rtl/ascon_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// ascon_ctrl_fsm
// Sequencer for the ASCON-128 datapath: initialisation (p^a), associated
// data and plaintext absorption (p^b per block), finalisation (p^a).
// Drives the sibling round counter (en/init_a/init_b) and reads back its
// round index.
// Ports:
//   clock_i      - clock, rising edge
//   reset_i      - synchronous active-high reset
//   bus          - ascon_ctrl_fsm_if.slave (handshake, counter, strobes)
//   o_dbg_state  - current FSM state, for observation only
// Parameters:
//   NB_AD_BLOCKS - associated-data blocks (1..15)
//   NB_PT_BLOCKS - plaintext blocks incl. the one absorbed at finalisation
// ---------------------------------------------------------------------------
module ascon_ctrl_fsm
   import ascon_pack::*;
#(
   parameter int NB_AD_BLOCKS = 1,
   parameter int NB_PT_BLOCKS = 4
) (
   input  logic              clock_i,
   input  logic              reset_i,
   ascon_ctrl_fsm_if.slave   bus,
   output state_t            o_dbg_state
);

   // Last AD block index, and the last PT block index that goes through
   // PT_ROUNDS (the final PT block is absorbed in FINAL_WAIT instead).
   localparam logic [3:0] AD_LAST = 4'(NB_AD_BLOCKS - 1);
   localparam logic [3:0] PT_LAST = (NB_PT_BLOCKS >= 2) ? 4'(NB_PT_BLOCKS - 2) : 4'd0;

   state_t     r_state, w_next_state;
   logic [3:0] r_blk, w_blk_next;
   logic       r_cipher_valid, r_tag_valid;
   logic       w_cipher_set, w_tag_set;
   logic       w_last;

   logic w_ready, w_en, w_init_a, w_init_b, w_perm, w_load_init;
   logic w_xor_data, w_xor_kb, w_xor_ke, w_xor_dom, w_done;

   assign w_last = (bus.round_i == LAST_ROUND);

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         r_state        <= S_IDLE;
         r_blk          <= 4'd0;
         r_cipher_valid <= 1'b0;
         r_tag_valid    <= 1'b0;
      end else begin
         r_state        <= w_next_state;
         r_blk          <= w_blk_next;
         r_cipher_valid <= w_cipher_set;
         r_tag_valid    <= w_tag_set;
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_blk_next   = r_blk;
      w_cipher_set = 1'b0;
      w_tag_set    = 1'b0;
      w_ready      = 1'b0;
      w_en         = 1'b0;
      w_init_a     = 1'b0;
      w_init_b     = 1'b0;
      w_perm       = 1'b0;
      w_load_init  = 1'b0;
      w_xor_data   = 1'b0;
      w_xor_kb     = 1'b0;
      w_xor_ke     = 1'b0;
      w_xor_dom    = 1'b0;
      w_done       = 1'b0;

      case (r_state)
         S_IDLE, S_DONE: begin
            w_done = (r_state == S_DONE);
            if (bus.start_i) begin
               w_en         = 1'b1;
               w_init_a     = 1'b1;
               w_blk_next   = 4'd0;
               w_next_state = S_INIT;
            end
         end
         S_INIT: begin
            w_perm      = 1'b1;
            w_en        = 1'b1;
            w_load_init = (bus.round_i == ROUND_A_START);
            if (w_last) begin
               w_xor_ke     = 1'b1;
               w_init_b     = 1'b1;
               w_next_state = S_AD_WAIT;
            end
         end
         S_AD_WAIT: begin
            // Counter parks at 6 while stalled; accepting a block runs
            // round 6 in this same cycle.
            w_ready = 1'b1;
            if (bus.data_valid_i) begin
               w_perm       = 1'b1;
               w_xor_data   = 1'b1;
               w_en         = 1'b1;
               w_next_state = S_AD_ROUNDS;
            end
         end
         S_AD_ROUNDS: begin
            w_perm = 1'b1;
            w_en   = 1'b1;
            if (w_last) begin
               if (r_blk != AD_LAST) begin
                  w_init_b     = 1'b1;
                  w_blk_next   = r_blk + 4'd1;
                  w_next_state = S_AD_WAIT;
               end else begin
                  w_xor_dom  = 1'b1;
                  w_blk_next = 4'd0;
                  if (NB_PT_BLOCKS > 1) begin
                     w_init_b     = 1'b1;
                     w_next_state = S_PT_WAIT;
                  end else begin
                     w_init_a     = 1'b1;
                     w_next_state = S_FINAL_WAIT;
                  end
               end
            end
         end
         S_PT_WAIT: begin
            w_ready      = 1'b1;
            w_cipher_set = bus.data_valid_i;
            if (bus.data_valid_i) begin
               w_perm       = 1'b1;
               w_xor_data   = 1'b1;
               w_en         = 1'b1;
               w_next_state = S_PT_ROUNDS;
            end
         end
         S_PT_ROUNDS: begin
            w_perm = 1'b1;
            w_en   = 1'b1;
            if (w_last) begin
               if (r_blk < PT_LAST) begin
                  w_init_b     = 1'b1;
                  w_blk_next   = r_blk + 4'd1;
                  w_next_state = S_PT_WAIT;
               end else begin
                  w_init_a     = 1'b1;
                  w_next_state = S_FINAL_WAIT;
               end
            end
         end
         S_FINAL_WAIT: begin
            w_ready      = 1'b1;
            w_cipher_set = bus.data_valid_i;
            if (bus.data_valid_i) begin
               w_perm       = 1'b1;
               w_xor_data   = 1'b1;
               w_xor_kb     = 1'b1;
               w_en         = 1'b1;
               w_next_state = S_FINAL;
            end
         end
         S_FINAL: begin
            w_perm = 1'b1;
            w_en   = 1'b1;
            if (w_last) begin
               w_xor_ke     = 1'b1;
               w_tag_set    = 1'b1;
               w_next_state = S_DONE;
            end
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   assign bus.data_ready_o    = w_ready;
   assign bus.en_cpt_o        = w_en;
   assign bus.init_a_o        = w_init_a;
   assign bus.init_b_o        = w_init_b;
   assign bus.perm_en_o       = w_perm;
   assign bus.load_init_o     = w_load_init;
   assign bus.xor_data_o      = w_xor_data;
   assign bus.xor_key_begin_o = w_xor_kb;
   assign bus.xor_key_end_o   = w_xor_ke;
   assign bus.xor_domain_o    = w_xor_dom;
   assign bus.cipher_valid_o  = r_cipher_valid;
   assign bus.tag_valid_o     = r_tag_valid;
   assign bus.done_o          = w_done;
   assign o_dbg_state         = r_state;

endmodule

// File: doc/ascon_ctrl_fsm.md
Name: ascon_ctrl_fsm

Overview:
Control state machine for the ASCON-128 datapath. It drives the double-init round counter's en/init_a/init_b controls and consumes the 4-bit round index the counter returns. It sequences initialisation (p^a), associated-data and plaintext absorption (p^b), and finalisation (p^a), and emits the per-round datapath strobes. It sits directly upstream of the round counter and beside the permutation datapath in the top level.

Parameters:
NB_AD_BLOCKS, 1, number of 64-bit associated-data blocks (legal range 1..15).
NB_PT_BLOCKS, 4, number of 64-bit plaintext blocks, including the block absorbed at finalisation (legal range 1..15).

Ports:
clock_i  in  1  clock; all logic on rising edge.
reset_i  in  1  synchronous reset, active-high.
start_i  in  1  start a new encryption; sampled only in IDLE/DONE.
data_valid_i  in  1  upstream has a data block available.
round_i  in  4  current round index from the round counter.
data_ready_o  out  1  block accepted when data_valid_i && data_ready_o.
en_cpt_o  out  1  round counter enable.
init_a_o  out  1  round counter load 0; only meaningful with en_cpt_o.
init_b_o  out  1  round counter load 6; only meaningful with en_cpt_o.
perm_en_o  out  1  state register captures the round output this cycle.
load_init_o  out  1  round input = IV||K||N.
xor_data_o  out  1  XOR data block into rate at round input.
xor_key_begin_o  out  1  XOR 0^*||K at round input.
xor_key_end_o  out  1  XOR 0^*||K at round output.
xor_domain_o  out  1  XOR domain-separation bit into LSB at round output.
cipher_valid_o  out  1  registered 1-cycle pulse: ciphertext register valid.
tag_valid_o  out  1  registered 1-cycle pulse: tag valid.
done_o  out  1  high in DONE.

Behaviour:
- Reset (reset_i=1 at a clock edge, any state): state=IDLE, block counter=0, cipher_valid_o=0, tag_valid_o=0.
- All other outputs are Moore/Mealy combinational decodes of state, round_i and data_valid_i. They are 0 in IDLE unless start_i=1.
- The round counter increments when enabled; init_a takes priority over init_b.
- States: IDLE, INIT, AD_WAIT, AD_ROUNDS, PT_WAIT, PT_ROUNDS, FINAL_WAIT, FINAL, DONE.
- IDLE/DONE with start_i=1:
  - en_cpt_o=1, init_a_o=1, block counter cleared, next state INIT.
  - done_o drops on the next cycle.
  - start_i is ignored in all other states.
- INIT: perm_en_o=1 and en_cpt_o=1 every cycle. load_init_o=1 when round_i==0.
  - At round_i==11: xor_key_end_o=1, init_b_o=1, next AD_WAIT.
- AD_WAIT: data_ready_o=1, counter holds 6.
  - On data_valid_i: perm_en_o=1, xor_data_o=1, en_cpt_o=1 (6 to 7), next AD_ROUNDS.
  - Otherwise stall; no strobes.
- AD_ROUNDS: perm_en_o=1, en_cpt_o=1.
  - At round_i==11, if the block counter is not at NB_AD_BLOCKS-1: init_b_o=1, block counter +1, next AD_WAIT.
  - Else (last AD block): xor_domain_o=1 and block counter cleared. If NB_PT_BLOCKS>1: init_b_o=1, next PT_WAIT. If NB_PT_BLOCKS==1: init_a_o=1, next FINAL_WAIT.
- PT_WAIT/PT_ROUNDS: same handshake and round behaviour as AD.
  - cipher_valid_o pulses the cycle after each accepted PT block.
  - At round_i==11, if the block counter is below NB_PT_BLOCKS-2: init_b_o=1, block counter +1, back to PT_WAIT.
  - Else: init_a_o=1, next FINAL_WAIT.
- FINAL_WAIT: data_ready_o=1, counter holds 0.
  - On data_valid_i: perm_en_o=1, xor_data_o=1, xor_key_begin_o=1, en_cpt_o=1, next FINAL.
  - cipher_valid_o pulses the next cycle.
- FINAL: perm_en_o=1, en_cpt_o=1.
  - At round_i==11: xor_key_end_o=1, next DONE.
  - tag_valid_o pulses the cycle DONE is entered.
- DONE: done_o=1, all strobes 0, counter not enabled.
- Simultaneous events:
  - data_valid_i outside the WAIT states is ignored; data_ready_o is never high outside WAIT states.
  - reset_i wins over every other input.
- Latency (data_valid_i held high, defaults), start sampled at T0:
  - INIT rounds T1..T12; AD T13..T18; PT blocks at T19, T25, T31.
  - FINAL T37..T48; tag_valid_o at T49.
  - cipher_valid_o at T20, T26, T32, T38.

Decomposition:
- ascon_pack holds:
  - typedef enum of the nine states.
  - constants ROUND_A_START=4'd0, ROUND_B_START=4'd6, LAST_ROUND=4'd11.
- No sub-module. The round counter remains a sibling instance in the top level, wired to en_cpt_o/init_a_o/init_b_o/round_i.
- The block counter is an internal 4-bit register.

Test Plan:
- Reset: reset_i=1 mid-FINAL, then released → state IDLE, all outputs 0, no tag_valid_o; new start_i gives init_a_o=1 in the same cycle.
- Nominal, defaults, data_valid_i=1 constantly, start at T0 → load_init_o at T1; xor_key_end_o at T12 and T48; xor_domain_o at T18; tag_valid_o only at T49; done_o from T49.
- Stall: data_valid_i=0 for 5 cycles in AD_WAIT → round_i holds 6, perm_en_o=0, data_ready_o=1 throughout; tag_valid_o slips to T54.
- Ignored inputs: start_i pulsed during INIT and data_valid_i during PT_ROUNDS → no change in state sequence or strobes.
- NB_PT_BLOCKS=1, NB_AD_BLOCKS=2 → two AD p^b; init_a_o at the end of the second AD block; exactly one cipher_valid_o; tag_valid_o at T37.
- Restart from DONE: start_i=1 → init_a_o=1, done_o=0 next cycle, full sequence repeats with identical timing.
